vga_pixel_sink: RTL and testbench
=================================

Name: vga_pixel_sink

Overview:
Downstream consumer of the pixel loader's 24-bit RGB stream. It buffers incoming pixels in a small FIFO and drives VGA timing (HSYNC/VSYNC/DE) with registered RGB. It back-pressures the loader through PIX_REQ, which connects to the loader's INTERFACE_EN. It also reports FIFO underflow and overflow as sticky flags.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, HSYNC pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, VSYNC pulse width (lines)
V_BP, 33, vertical back porch (lines); must be >= 1
FIFO_DEPTH, 8, pixel FIFO entries; power of 2, >= 4

Ports:
CLK  in  1  pixel clock; all logic on the rising edge
RESET_N  in  1  asynchronous, active-low reset
PIX_IN  in  24  RGB pixel from the loader, {R[23:16],G[15:8],B[7:0]}
PIX_VALID  in  1  PIX_IN is written into the FIFO this cycle
PIX_REQ  out  1  FIFO has room; drives the loader's INTERFACE_EN
RGB  out  24  pixel to the DAC; 0 outside the active region
HSYNC  out  1  horizontal sync, active-low
VSYNC  out  1  vertical sync, active-low
DE  out  1  active video
UNDERFLOW  out  1  sticky: a pixel was due while the FIFO was empty
OVERFLOW  out  1  sticky: PIX_VALID arrived while the FIFO was full

Behaviour:
- Reset (async assert, sync release):
  - Outputs: RGB=0, HSYNC=1, VSYNC=1, DE=0, PIX_REQ=0, UNDERFLOW=0, OVERFLOW=0.
  - FIFO is emptied.
  - h_cnt=0 and v_cnt=V_TOTAL-1, where V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP. This gives one back-porch line for prefill before the first active pixel.
  - Reset mid-frame discards all FIFO contents immediately.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps, with H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 and wraps.
  - Counter widths are clog2(total).
- Timing decode, from the current counters:
  - active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE)
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
- Output stage:
  - HSYNC=~hs, VSYNC=~vs and DE=active are all registered: one cycle of latency, mutually aligned.
  - RGB is registered in the same cycle as DE.
  - If active and the FIFO is not empty, the FIFO is popped and RGB takes the head entry.
  - If active and the FIFO is empty, RGB=0, UNDERFLOW is set, and the pixel is skipped (no pop).
  - If not active, RGB=0.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr and count (0..FIFO_DEPTH).
  - Push when PIX_VALID; pop as described above.
  - Push on full without a same-cycle pop: data is dropped, OVERFLOW is set, state is unchanged.
  - Push and pop in the same cycle while full: both happen and count is unchanged.
  - Push and pop in the same cycle while empty: there is no bypass. The pop is an underflow and the push is stored.
  - Pointers wrap modulo FIFO_DEPTH.
- PIX_REQ is registered: PIX_REQ <= (next count < FIFO_DEPTH-2).
  - The two spare slots absorb the loader's in-flight read (LER -> INCREMENTAR -> PREPARAR).
- UNDERFLOW and OVERFLOW clear only on reset.

Decomposition:
- Shared package vga_pkg: default 640x480 timing constants, RGB width (24), and a clog2 function.
- One natural sub-module, pixel_fifo: parameters WIDTH and DEPTH; ports push, pop, din, dout, empty, full, count.
- Timing counters, sync decode and the output register stay in vga_pixel_sink.

Test Plan:
All scenarios use small timing: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=2 (H_TOTAL=15); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); FIFO_DEPTH=8.

1. Reset and timing: hold PIX_VALID=1 with an incrementing PIX_IN. Required:
   - The first DE rises 16 cycles after RESET_N release (15 prefill plus 1 latency).
   - DE is high for 8 cycles per line on 4 lines.
   - HSYNC is low for 3 cycles, starting 10 cycles after each DE rise.
   - VSYNC is low for exactly 30 cycles per 120-cycle frame.
2. Pixel order: push 0x000001..0x000020. RGB during DE must be 0x000001, 0x000002, ... in order, with RGB=0 while DE=0. UNDERFLOW stays 0.
3. Underflow: no PIX_VALID after reset. At the first DE cycle RGB=0 and UNDERFLOW=1, and UNDERFLOW remains 1 after later refill.
4. Back-pressure and overflow: push 8 pixels during blanking.
   - PIX_REQ drops after count reaches 6.
   - A 9th push while full sets OVERFLOW, and the 9th value never appears on RGB.
5. Simultaneous push/pop: with the FIFO full during active video and PIX_VALID=1 every cycle, count stays 8 and OVERFLOW stays 0.
6. Async reset mid-line: assert RESET_N=0 at h_cnt=4 of an active line. All outputs return to their reset values within the same cycle, without waiting for a clock edge. After release, the timing of scenario 1 repeats exactly.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants and helpers.
//   RGB_W            : pixel width {R,G,B}
//   *_DEF            : default 640x480 timing and FIFO depth
//   clog2()          : ceiling log2 for counter/pointer widths
package vga_pkg;

    localparam int unsigned RGB_W          = 24;

    localparam int unsigned H_ACTIVE_DEF   = 640;
    localparam int unsigned H_FP_DEF       = 16;
    localparam int unsigned H_SYNC_DEF     = 96;
    localparam int unsigned H_BP_DEF       = 48;

    localparam int unsigned V_ACTIVE_DEF   = 480;
    localparam int unsigned V_FP_DEF       = 10;
    localparam int unsigned V_SYNC_DEF     = 2;
    localparam int unsigned V_BP_DEF       = 33;

    localparam int unsigned FIFO_DEPTH_DEF = 8;

    // Smallest r with 2**r >= n.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Circular pixel buffer.
//   clk, rst_n : clock, async active-low reset (empties the buffer)
//   push, din  : write request and data; dropped when full unless a pop happens
//   pop        : read request; ignored when empty (no bypass)
//   dout       : head entry
//   empty/full : registered status
//   count      : occupancy 0..DEPTH
module pixel_fifo
    import vga_pkg::*;
#(
    parameter  int unsigned WIDTH = RGB_W,
    parameter  int unsigned DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned AW    = clog2(DEPTH),
    localparam int unsigned CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    assign dout = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    // Storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vga_pixel_sink.sv
// VGA pixel sink: buffers the loader's RGB stream and drives VGA timing.
//   CLK, RESET_N : pixel clock, async active-low reset
//   PIX_IN       : {R,G,B} pixel from the loader
//   PIX_VALID    : PIX_IN written into the FIFO this cycle
//   PIX_REQ      : FIFO has room (loader INTERFACE_EN)
//   RGB          : pixel to the DAC, 0 outside active video
//   HSYNC, VSYNC : active-low syncs
//   DE           : active video
//   UNDERFLOW    : sticky, pixel due while FIFO empty
//   OVERFLOW     : sticky, push dropped because FIFO full
module vga_pixel_sink
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [RGB_W-1:0] PIX_IN,
    input  logic             PIX_VALID,
    output logic             PIX_REQ,
    output logic [RGB_W-1:0] RGB,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             DE,
    output logic             UNDERFLOW,
    output logic             OVERFLOW
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = clog2(H_TOTAL);
    localparam int unsigned VW      = clog2(V_TOTAL);
    localparam int unsigned CW      = clog2(FIFO_DEPTH + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] REQ_LIMIT = CW'(FIFO_DEPTH - 2);

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic             active;
    logic             hs;
    logic             vs;
    logic             pop;
    logic             push_ok;
    logic [CW-1:0]    count_nxt;

    logic [RGB_W-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CW-1:0]    fifo_count;

    pixel_fifo #(
        .WIDTH (RGB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (PIX_VALID),
        .pop   (pop),
        .din   (PIX_IN),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Timing decode from the current counters, plus FIFO occupancy look-ahead.
    always_comb begin
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs        = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs        = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        pop       = active && !fifo_empty;
        push_ok   = PIX_VALID && (!fifo_full || pop);
        count_nxt = fifo_count + CW'(push_ok) - CW'(pop);
    end

    // Counters and registered outputs. v_cnt starts on the last back-porch
    // line so the loader gets one line to prefill before the first pixel.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            h_cnt     <= '0;
            v_cnt     <= V_LAST;
            RGB       <= '0;
            HSYNC     <= 1'b1;
            VSYNC     <= 1'b1;
            DE        <= 1'b0;
            PIX_REQ   <= 1'b0;
            UNDERFLOW <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end

            DE    <= active;
            HSYNC <= ~hs;
            VSYNC <= ~vs;
            RGB   <= pop ? fifo_dout : '0;

            if (active && fifo_empty)                UNDERFLOW <= 1'b1;
            if (PIX_VALID && fifo_full && !pop)      OVERFLOW  <= 1'b1;

            // Two spare slots cover the loader's in-flight read.
            PIX_REQ <= (count_nxt < REQ_LIMIT);
        end
    end

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Self-checking bench for vga_pixel_sink using small timing (15 x 8, depth 8).
module tb_vga_pixel_sink;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int DEP = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pix_in;
    logic        pix_valid;
    logic        pix_req;
    logic [23:0] rgb;
    logic        hsync, vsync, de, underflow, overflow;

    always #5 clk = ~clk;

    vga_pixel_sink #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .FIFO_DEPTH (DEP)
    ) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .PIX_IN    (pix_in),
        .PIX_VALID (pix_valid),
        .PIX_REQ   (pix_req),
        .RGB       (rgb),
        .HSYNC     (hsync),
        .VSYNC     (vsync),
        .DE        (de),
        .UNDERFLOW (underflow),
        .OVERFLOW  (overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: time index since reset plus a pixel queue.
    int          k;
    logic [23:0] q[$];
    logic [23:0] m_rgb;
    logic        m_hs, m_vs, m_de, m_req, m_uf, m_of;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Raster position held by the counters after kk clock edges.
    function automatic int pos_p(input int kk);
        return ((VT - 1) * HT + kk) % FR;
    endfunction
    function automatic int pos_h(input int kk);
        return pos_p(kk) % HT;
    endfunction
    function automatic int pos_v(input int kk);
        return pos_p(kk) / HT;
    endfunction
    function automatic bit pos_act(input int kk);
        return (pos_h(kk) < HA) && (pos_v(kk) < VA);
    endfunction

    task automatic model_reset();
        k = 0;
        q.delete();
        m_rgb = '0; m_hs = 1'b1; m_vs = 1'b1; m_de = 1'b0;
        m_req = 1'b0; m_uf = 1'b0; m_of = 1'b0;
    endtask

    task automatic model_step();
        int  h, v;
        bit  act, popped;
        h      = pos_h(k);
        v      = pos_v(k);
        act    = pos_act(k);
        popped = act && (q.size() > 0);
        m_de   = act;
        m_hs   = !((h >= HA + HF) && (h < HA + HF + HS));
        m_vs   = !((v >= VA + VF) && (v < VA + VF + VS));
        m_rgb  = popped ? q.pop_front() : 24'h0;
        if (act && !popped) m_uf = 1'b1;
        if (pix_valid) begin
            if (q.size() < DEP) q.push_back(pix_in);
            else                m_of = 1'b1;
        end
        m_req = (q.size() < DEP - 2);
        k++;
    endtask

    task automatic compare_all();
        chk("rgb",       32'(rgb),       32'(m_rgb));
        chk("hsync",     32'(hsync),     32'(m_hs));
        chk("vsync",     32'(vsync),     32'(m_vs));
        chk("de",        32'(de),        32'(m_de));
        chk("pix_req",   32'(pix_req),   32'(m_req));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("overflow",  32'(overflow),  32'(m_of));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        pix_valid = 1'b0;
        pix_in    = '0;
        rst_n     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst_n = 1'b1;
    endtask

    // Frame timing measurements with a continuous incrementing stream.
    task automatic run_timing(input string tag);
        int  de_first, hs_first, de_cnt, vs_low;
        bit  prev_de, prev_hs;
        de_first = -1; hs_first = -1; de_cnt = 0; vs_low = 0;
        prev_de = 1'b0; prev_hs = 1'b1;
        pix_valid = 1'b1;
        pix_in    = 24'h000001;
        for (int c = 1; c <= 2 * FR; c++) begin
            cycle();
            pix_in = pix_in + 24'h1;
            if (de && !prev_de && de_first < 0) de_first = c;
            if (!hsync && prev_hs && de_first >= 0 && hs_first < 0) hs_first = c;
            if (c <= FR && de)     de_cnt++;
            if (c <= FR && !vsync) vs_low++;
            prev_de = de;
            prev_hs = hsync;
        end
        chk({tag, "_de_first"}, 32'(de_first), 32'd16);
        chk({tag, "_de_cnt"},   32'(de_cnt),   32'(HA * VA));
        chk({tag, "_hs_off"},   32'(hs_first - de_first), 32'd10);
        chk({tag, "_vs_low"},   32'(vs_low),   32'd30);
    endtask

    initial begin
        int          px, exp_px;
        bit          seen, found;
        int          pct;

        // 1. reset and timing
        do_reset();
        run_timing("t1");

        // 2. pixel order with a loader that follows PIX_REQ
        do_reset();
        px = 1; exp_px = 1;
        repeat (100) begin
            pix_valid = pix_req && (px <= 32);
            pix_in    = 24'(px);
            cycle();
            if (pix_valid) px++;
            if (de) begin
                chk("order", 32'(rgb), 32'(exp_px));
                exp_px++;
            end
        end
        chk("order_n",   32'(exp_px),    32'd33);
        chk("order_uf",  32'(underflow), 32'd0);

        // 3. underflow with no prefill, then refill
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            cycle();
            if (c == 16) begin
                chk("uf_de",  32'(de),        32'd1);
                chk("uf_rgb", 32'(rgb),       32'd0);
                chk("uf_set", 32'(underflow), 32'd1);
            end
        end
        repeat (150) begin
            pix_valid = ($urandom_range(0, 1) == 1);
            pix_in    = 24'($urandom);
            cycle();
        end
        chk("uf_sticky", 32'(underflow), 32'd1);

        // 4. back-pressure and overflow during the prefill line
        do_reset();
        for (int i = 0; i < 9; i++) begin
            pix_valid = 1'b1;
            pix_in    = (i == 8) ? 24'hBAD009 : 24'(24'hA0 + i);
            cycle();
            if (i < 8) chk("req_bp", 32'(pix_req), 32'((i + 1) < 6));
        end
        chk("of_set", 32'(overflow), 32'd1);
        pix_valid = 1'b0;
        seen = 1'b0;
        repeat (FR) begin
            cycle();
            if (rgb == 24'hBAD009) seen = 1'b1;
        end
        chk("drop9", 32'(seen), 32'd0);

        // 5. full FIFO with push and pop every active cycle
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pix_valid = 1'b1;
            pix_in    = 24'(24'hC0 + i);
            cycle();
        end
        repeat (FR) begin
            pix_valid = pos_act(k);
            pix_in    = 24'($urandom);
            cycle();
            chk("cnt8", 32'(dut.fifo_count), 32'd8);
        end
        chk("of_clear", 32'(overflow), 32'd0);

        // Random traffic at several densities, ignoring PIX_REQ
        do_reset();
        for (int f = 0; f < 3; f++) begin
            pct = (f == 0) ? 30 : (f == 1) ? 60 : 95;
            repeat (FR) begin
                pix_valid = ($urandom_range(0, 99) < pct);
                pix_in    = 24'($urandom);
                cycle();
            end
        end

        // 6. async reset at h_cnt=4 of an active line
        do_reset();
        pix_valid = 1'b1;
        pix_in    = 24'h111111;
        found = 1'b0;
        for (int c = 0; c < 2 * FR && !found; c++) begin
            if (pos_h(k) == 4 && pos_v(k) == 1) found = 1'b1;
            else begin
                cycle();
                pix_in = pix_in + 24'h1;
            end
        end
        chk("mid_found", 32'(found), 32'd1);
        chk("mid_de_pre", 32'(de), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        run_timing("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
